// File: rtl/regfile_pkg.sv
// Shared constants, defaults and index helpers for the multi-port register file.
package regfile_pkg;

    // Architectural register indices with a fixed role
    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_RA   = 1;
    localparam int unsigned REG_SP   = 2;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 32;

    // Index width for a register count; never narrower than one bit
    function automatic int unsigned addr_width(input int unsigned num_regs);
        return (num_regs > 2) ? $clog2(num_regs) : 1;
    endfunction

    typedef logic [addr_width(DEF_NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index mux, x0 forcing, busy lookup.
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = addr_width(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] regs_i [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              issue_i,
    input  logic [ADDR_W-1:0] issue_rd_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

`ifndef REGFILE_BYPASS_EN
    // Write/issue inputs only matter when the bypass path exists
    logic unused_bypass;
    assign unused_bypass = ^{we_i, waddr_i, wdata_i, issue_i, issue_rd_i};
`endif

    // Select stored value and busy bit; bypass overrides, x0 overrides everything
    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        rd_busy_o = busy_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
        if (we_i && (waddr_i != '0) && (rd_addr_i == waddr_i)) begin
            rd_data_o = wdata_i;
            // A new producer issued this cycle keeps the register busy
            rd_busy_o = issue_i && (issue_rd_i == waddr_i);
        end
`endif
        if (rd_addr_i == '0) begin
            rd_data_o = '0;
            rd_busy_o = 1'b0;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Parametrised multi-read-port integer register file with busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module register_file_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned SP_IDX   = REG_SP,
    parameter logic [31:0] SP_INIT  = 32'h400,
    localparam int unsigned ADDR_W  = addr_width(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     issue_i,
    input  logic [ADDR_W-1:0]        issue_rd_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o
);

    localparam logic [DATA_W-1:0] SP_RST = DATA_W'(SP_INIT);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Writeback into storage; x0 writes are dropped
    always_comb begin
        regs_d = regs_q;
        if (we_i && (waddr_i != '0)) begin
            regs_d[waddr_i] = wdata_i;
        end
    end

    // Scoreboard: retire first, then issue so a new producer wins on the same index
    always_comb begin
        busy_d = busy_q;
        if (we_i && (waddr_i != '0)) begin
            busy_d[waddr_i] = 1'b0;
        end
        if (issue_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous active-low reset taking priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= (i == int'(SP_IDX)) ? SP_RST : '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W)
        ) u_rd_port (
            .rd_addr_i  (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .regs_i     (regs_q),
            .busy_i     (busy_q),
            .we_i       (we_i),
            .waddr_i    (waddr_i),
            .wdata_i    (wdata_i),
            .issue_i    (issue_i),
            .issue_rd_i (issue_rd_i),
            .rd_data_o  (rd_data_o[k*DATA_W +: DATA_W]),
            .rd_busy_o  (rd_busy_o[k])
        );
    end

endmodule
